// File: rtl/alu_arbiter_if.sv
// Requester channel to the ALU arbiter: request handshake toward the block and
// the captured response back to the requester.
interface alu_arbiter_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [3:0] req_op;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [2:0] rsp_flags;
  logic       rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation runs IDLE -> EXEC -> RESP; a response is held until its owner consumes it.
module alu_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave ch0,
  alu_arbiter_if.slave ch1,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic [3:0]   alu_sel,
  input  logic [7:0]   alu_result,
  input  logic         alu_carry,
  input  logic         alu_overflow,
  input  logic         alu_zero,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic            owner_q;
  logic            grant;
  logic            ready0, ready1;
  logic            handshake;
  logic            owner_rsp_ready;
  logic [1:0][7:0] res_q;
  logic [1:0][2:0] flags_q;
  logic [1:0]      err_q;

  // A lone valid requester wins; with both valid, rr picks.
  always_comb begin
    grant = ch1.req_valid;
    if (ch0.req_valid && ch1.req_valid) grant = rr_q;
  end

  assign ready0          = (state_q == StIdle) && ch0.req_valid && !grant;
  assign ready1          = (state_q == StIdle) && ch1.req_valid && grant;
  assign handshake       = ready0 || ready1;
  assign owner_rsp_ready = owner_q ? ch1.rsp_ready : ch0.rsp_ready;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: if (handshake) state_d = StExec;
      StExec: state_d = StResp;
      StResp: begin
        if (owner_rsp_ready) begin
          state_d = StIdle;
          rr_d    = ~owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (handshake) begin
        owner_q <= grant;
        alu_a   <= grant ? ch1.req_a  : ch0.req_a;
        alu_b   <= grant ? ch1.req_b  : ch0.req_b;
        alu_sel <= grant ? ch1.req_op : ch0.req_op;
      end
    end
  end

  // Only the owner's response slot is written; the other keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= '0;
    end else if (state_q == StExec) begin
      err_q[owner_q] <= alu_sel[3];
      if (alu_sel[3]) begin
        res_q[owner_q]   <= '0;
        flags_q[owner_q] <= '0;
      end else begin
        res_q[owner_q]   <= alu_result;
        flags_q[owner_q] <= {alu_carry, alu_overflow, alu_zero};
      end
    end
  end

  assign busy          = (state_q != StIdle);
  assign ch0.req_ready = ready0;
  assign ch1.req_ready = ready1;

  assign ch0.rsp_valid  = (state_q == StResp) && !owner_q;
  assign ch0.rsp_result = res_q[0];
  assign ch0.rsp_flags  = flags_q[0];
  assign ch0.rsp_err    = err_q[0];

  assign ch1.rsp_valid  = (state_q == StResp) && owner_q;
  assign ch1.rsp_result = res_q[1];
  assign ch1.rsp_flags  = flags_q[1];
  assign ch1.rsp_err    = err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic, checked against a
// transaction-level model of grants, round-robin order and captured responses.
module tb_alu_arbiter;
  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpIll = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_sel;
  logic       alu_carry, alu_overflow, alu_zero, busy;
  logic [8:0] alu_wide;

  alu_arbiter_if ch0 ();
  alu_arbiter_if ch1 ();

  alu_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch0          (ch0),
    .ch1          (ch1),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Shared ALU: low 3 select bits choose the function; bit 3 is ignored here.
  always_comb begin
    alu_wide     = '0;
    alu_overflow = 1'b0;
    case (alu_sel[2:0])
      3'd0: begin
        alu_wide     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_wide[7] != alu_a[7]);
      end
      3'd1: begin
        alu_wide     = {1'b0, alu_a} - {1'b0, alu_b};
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_wide[7] != alu_a[7]);
      end
      3'd2:    alu_wide = {1'b0, alu_a & alu_b};
      3'd3:    alu_wide = {1'b0, alu_a | alu_b};
      3'd4:    alu_wide = {1'b0, alu_a ^ alu_b};
      3'd5:    alu_wide = {alu_a, 1'b0};
      3'd6:    alu_wide = {1'b0, ~alu_a};
      default: alu_wide = {1'b0, alu_b};
    endcase
    alu_result = alu_wide[7:0];
    alu_carry  = alu_wide[8];
    alu_zero   = (alu_wide[7:0] == 8'h00);
  end

  int         checks = 0;
  int         failures = 0;
  bit         m_rr;
  bit         m_owner;
  logic [7:0] m_res [2];
  logic [2:0] m_flg [2];
  logic       m_err [2];
  logic [7:0] m_alu_a, m_alu_b;
  logic [3:0] m_alu_sel;

  // Expected response as {err, carry, overflow, zero, result}, from integer arithmetic.
  function automatic logic [11:0] ref_op(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int ua, ub, sa, sb, u, s;
    logic c, v;
    logic [7:0] r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c  = 1'b0;
    v  = 1'b0;
    s  = 0;
    if (op[3]) return {1'b1, 11'h000};
    case (op[2:0])
      3'd0: begin u = ua + ub; c = (u > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      3'd1: begin u = ua - ub; c = (u < 0);   s = sa - sb; v = (s > 127) || (s < -128); end
      3'd2: u = ua & ub;
      3'd3: u = ua | ub;
      3'd4: u = ua ^ ub;
      3'd5: begin u = ua * 2; c = (u > 255); end
      3'd6: u = 255 - ua;
      default: u = ub;
    endcase
    r = u[7:0];
    return {1'b0, c, v, (r == 8'h00), r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input bit v0, input bit v1);
    check({tag, ".rsp0_valid"},  ch0.rsp_valid,  v0);
    check({tag, ".rsp1_valid"},  ch1.rsp_valid,  v1);
    check({tag, ".rsp0_result"}, ch0.rsp_result, m_res[0]);
    check({tag, ".rsp1_result"}, ch1.rsp_result, m_res[1]);
    check({tag, ".rsp0_flags"},  ch0.rsp_flags,  m_flg[0]);
    check({tag, ".rsp1_flags"},  ch1.rsp_flags,  m_flg[1]);
    check({tag, ".rsp0_err"},    ch0.rsp_err,    m_err[0]);
    check({tag, ".rsp1_err"},    ch1.rsp_err,    m_err[1]);
  endtask

  task automatic apply_reset(input string tag);
    ch0.req_valid = 1'b0;
    ch1.req_valid = 1'b0;
    ch0.rsp_ready = 1'b0;
    ch1.rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    m_rr      = 1'b0;
    m_owner   = 1'b0;
    m_res     = '{8'h00, 8'h00};
    m_flg     = '{3'b000, 3'b000};
    m_err     = '{1'b0, 1'b0};
    m_alu_a   = '0;
    m_alu_b   = '0;
    m_alu_sel = '0;
    check({tag, ".alu_a"},   alu_a,   m_alu_a);
    check({tag, ".alu_b"},   alu_b,   m_alu_b);
    check({tag, ".alu_sel"}, alu_sel, m_alu_sel);
    check({tag, ".busy"},    busy,    1'b0);
    check_rsp(tag, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Present a request pattern in IDLE and run it through the handshake and EXEC edges.
  task automatic issue(input bit v0, input bit v1,
                       input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] op0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] op1,
                       input string tag);
    bit w;
    logic [11:0] e;
    ch0.req_valid = v0; ch0.req_a = a0; ch0.req_b = b0; ch0.req_op = op0;
    ch1.req_valid = v1; ch1.req_a = a1; ch1.req_b = b1; ch1.req_op = op1;
    ch0.rsp_ready = 1'b0;
    ch1.rsp_ready = 1'b0;
    #1;
    w = (v0 && v1) ? m_rr : !v0;
    check({tag, ".idle_busy"}, busy, 1'b0);
    check({tag, ".ready0"}, ch0.req_ready, v0 && !w);
    check({tag, ".ready1"}, ch1.req_ready, v1 && w);
    @(posedge clk); #1;
    m_owner   = w;
    m_alu_a   = w ? a1 : a0;
    m_alu_b   = w ? b1 : b0;
    m_alu_sel = w ? op1 : op0;
    check({tag, ".exec_busy"}, busy, 1'b1);
    check({tag, ".exec_ready0"}, ch0.req_ready, 1'b0);
    check({tag, ".exec_ready1"}, ch1.req_ready, 1'b0);
    check({tag, ".alu_a"},   alu_a,   m_alu_a);
    check({tag, ".alu_b"},   alu_b,   m_alu_b);
    check({tag, ".alu_sel"}, alu_sel, m_alu_sel);
    check_rsp({tag, ".exec"}, 1'b0, 1'b0);
    // Winner withdraws and scrambles its inputs; the latched operands must not move.
    if (w) begin
      ch1.req_valid = 1'b0; ch1.req_a = 8'($urandom); ch1.req_op = 4'($urandom);
    end else begin
      ch0.req_valid = 1'b0; ch0.req_a = 8'($urandom); ch0.req_op = 4'($urandom);
    end
    @(posedge clk); #1;
    e = ref_op(m_alu_sel, m_alu_a, m_alu_b);
    m_res[w] = e[7:0];
    m_flg[w] = e[10:8];
    m_err[w] = e[11];
    check({tag, ".resp_busy"}, busy, 1'b1);
    check({tag, ".alu_a_hold"}, alu_a, m_alu_a);
    check({tag, ".alu_sel_hold"}, alu_sel, m_alu_sel);
    check_rsp({tag, ".resp"}, !w, w);
  endtask

  // Hold the response for `stall` cycles, then let the owner consume it.
  task automatic complete(input int stall, input string tag);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check({tag, ".stall_busy"}, busy, 1'b1);
      check({tag, ".stall_ready0"}, ch0.req_ready, 1'b0);
      check({tag, ".stall_ready1"}, ch1.req_ready, 1'b0);
      check_rsp({tag, ".stall"}, !m_owner, m_owner);
    end
    if (m_owner) ch1.rsp_ready = 1'b1;
    else         ch0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    m_rr = !m_owner;
    ch0.rsp_ready = 1'b0;
    ch1.rsp_ready = 1'b0;
    check({tag, ".done_busy"}, busy, 1'b0);
    check_rsp({tag, ".done"}, 1'b0, 1'b0);
  endtask

  initial begin
    ch0.req_valid = 1'b0; ch0.req_a = '0; ch0.req_b = '0; ch0.req_op = '0; ch0.rsp_ready = 1'b0;
    ch1.req_valid = 1'b0; ch1.req_a = '0; ch1.req_b = '0; ch1.req_op = '0; ch1.rsp_ready = 1'b0;
    #2;
    apply_reset("por");

    issue(1'b1, 1'b0, 8'd10, 8'd20, OpAdd, 8'd0, 8'd0, OpAdd, "single");
    check("single.result_30", ch0.rsp_result, 8'd30);
    check("single.flags_000", ch0.rsp_flags, 3'b000);
    check("single.err_0", ch0.rsp_err, 1'b0);
    complete(0, "single");
    ch0.req_valid = 1'b1;
    #1;
    check("single.ready_again", ch0.req_ready, 1'b1);
    ch0.req_valid = 1'b0;

    apply_reset("pre_contend");
    issue(1'b1, 1'b1, 8'd10, 8'd20, OpSub, 8'hAA, 8'h55, OpAnd, "contend_a");
    check("contend_a.req0_first", ch0.rsp_valid, 1'b1);
    check("contend_a.result_f6", ch0.rsp_result, 8'hF6);
    complete(0, "contend_a");
    issue(1'b0, 1'b1, 8'd0, 8'd0, OpAdd, 8'hAA, 8'h55, OpAnd, "contend_b");
    check("contend_b.result_00", ch1.rsp_result, 8'h00);
    check("contend_b.zero_flag", ch1.rsp_flags, 3'b001);
    complete(0, "contend_b");

    issue(1'b1, 1'b0, 8'd1, 8'd2, OpAdd, 8'd0, 8'd0, OpAdd, "fair_prep");
    complete(0, "fair_prep");
    issue(1'b1, 1'b1, 8'h0F, 8'hF0, OpOr, 8'd127, 8'd1, OpAdd, "ovf");
    check("ovf.req1_won", ch1.rsp_valid, 1'b1);
    check("ovf.result_80", ch1.rsp_result, 8'h80);
    check("ovf.flags_010", ch1.rsp_flags, 3'b010);
    complete(0, "ovf");
    issue(1'b1, 1'b1, 8'd3, 8'd4, OpAdd, 8'd5, 8'd6, OpAdd, "fair_next");
    check("fair_next.req0_won", ch0.rsp_valid, 1'b1);
    complete(0, "fair_next");
    ch1.req_valid = 1'b0;

    issue(1'b1, 1'b0, 8'd50, 8'd60, OpAdd, 8'd0, 8'd0, OpAdd, "bp");
    ch1.req_valid = 1'b1;
    complete(5, "bp");
    ch1.req_valid = 1'b0;

    issue(1'b1, 1'b0, 8'd3, 8'd4, OpIll, 8'd0, 8'd0, OpAdd, "illegal");
    check("illegal.err_1", ch0.rsp_err, 1'b1);
    check("illegal.result_0", ch0.rsp_result, 8'h00);
    check("illegal.flags_0", ch0.rsp_flags, 3'b000);
    complete(1, "illegal");

    ch0.req_valid = 1'b1; ch0.req_a = 8'd5; ch0.req_b = 8'd6; ch0.req_op = OpAdd;
    @(posedge clk); #1;
    check("midrst.in_exec", busy, 1'b1);
    ch0.req_valid = 1'b0;
    apply_reset("midrst");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("midrst.no_rsp0", ch0.rsp_valid, 1'b0);
      check("midrst.no_rsp1", ch1.rsp_valid, 1'b0);
      check("midrst.idle", busy, 1'b0);
    end
    issue(1'b1, 1'b0, 8'd1, 8'd1, OpAdd, 8'd0, 8'd0, OpAdd, "after_rst");
    check("after_rst.result_2", ch0.rsp_result, 8'd2);
    complete(0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      bit rv0, rv1;
      rv0 = 1'($urandom);
      rv1 = 1'($urandom);
      if (!rv0 && !rv1) rv0 = 1'b1;
      issue(rv0, rv1, 8'($urandom), 8'($urandom), 4'($urandom),
            8'($urandom), 8'($urandom), 4'($urandom), $sformatf("rand%0d", i));
      complete($urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
